// File: rtl/mux41_rr_sched.sv
// mux41_rr_sched: round-robin arbiter driving a registered 4:1 one-bit mux (S1/S0 = sel).
// Define MUX41_SCHED_LOCK_EN to add a lock input that suppresses hold-limit rotation.
module mux41_rr_sched #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
`ifdef MUX41_SCHED_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       y
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic [1:0] last;
    logic [2:0] first, nxt;
    logic       locked;

    // Returns {found, index}, scanning p+1, p+2, p+3 and optionally p itself.
    function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] r, input logic incl);
        logic [2:0] res;
        logic [1:0] i;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            i = p + 2'(k);
            if (r[i] && (k != 4 || incl)) res = {1'b1, i};
        end
        return res;
    endfunction

    always_comb begin
        first = pick(last, req, 1'b1);
        nxt   = pick(sel, req, 1'b0);
    end

`ifdef MUX41_SCHED_LOCK_EN
    assign locked = lock;
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'b00;
            valid <= 1'b0;
            y     <= 1'b0;
            cnt   <= 4'd0;
            last  <= 2'd3;
        end else begin
            valid <= |gnt;
            y     <= |gnt & d[sel];
            if (state == IDLE) begin
                gnt <= 4'b0000;
                if (first[2]) begin
                    state <= GRANT;
                    gnt   <= 4'b0001 << first[1:0];
                    sel   <= first[1:0];
                    last  <= first[1:0];
                    cnt   <= 4'd0;
                end
            end else if (!req[sel] || (!locked && cnt == 4'(HOLD_MAX - 1))) begin
                // Release or hold-limit rotation: hand over directly with no idle bubble.
                if (nxt[2]) begin
                    gnt  <= 4'b0001 << nxt[1:0];
                    sel  <= nxt[1:0];
                    last <= nxt[1:0];
                    cnt  <= 4'd0;
                end else if (!req[sel]) begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                end
            end else if (!locked) begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule
